cs_byte_packer: RTL and testbench

//   Upstream feeder for the CS checksum core. Collects a byte-serial stream into one
//   512-bit frame: the 384-bit field 1 followed by the 128-bit field 2.

---
 rtl/cs_byte_packer.sv | 175 +++++++++++++++++
 tb/tb_cs_byte_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cs_byte_packer.sv
// cs_byte_packer: packs a byte-serial stream into one WIDTH_DATA_1+WIDTH_DATA_2 bit frame for the CS core.
// Latency: the frame strobe (out_valid) comes 1 cycle after the last byte transfer.
// Backpressure: in_ready drops after a full frame until cs_done arrives; a sticky err flags a CS core that never answers.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_byte/_valid  byte stream in; in_ready is the accept handshake (transfer = valid & ready)
//   data/out_valid  packed frame and its one-cycle strobe; the first byte lands in data[W-1 -: 8]
//   cs_done         CS has consumed the frame
//   err             sticky watchdog flag: WAIT lasted TIMEOUT cycles
//
// Optional feature macro: CS_PACK_PREFILL_EN. It adds a shadow buffer that keeps accepting
// bytes while a frame is waiting on CS.
module cs_byte_packer #(
    parameter int WIDTH_DATA_1 = 384,
    parameter int WIDTH_DATA_2 = 128,
    parameter int TIMEOUT      = 100
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [7:0]                           in_byte,
    input  logic                                 in_byte_valid,
    output logic                                 in_ready,
    output logic [WIDTH_DATA_1+WIDTH_DATA_2-1:0] data,
    output logic                                 out_valid,
    input  logic                                 cs_done,
    output logic                                 err
);
    localparam int W  = WIDTH_DATA_1 + WIDTH_DATA_2;
    localparam int NB = W / 8;
    localparam int CW = $clog2(NB);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {FILL, SEND, WAIT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  data_q, data_d;
    logic [TW-1:0] wdog_q, wdog_d;
    logic          err_q, err_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic          xfer;

`ifdef CS_PACK_PREFILL_EN
    logic [W-1:0]  sh_q, sh_d;
    logic [CW-1:0] sh_cnt_q, sh_cnt_d;
    logic          sh_full_q, sh_full_d;
`endif

    // in_ready is registered, so a transfer is exactly what the upstream side sees.
    assign xfer = in_byte_valid & in_ready_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        wdog_d  = wdog_q;
        err_d   = err_q;
`ifdef CS_PACK_PREFILL_EN
        sh_d      = sh_q;
        sh_cnt_d  = sh_cnt_q;
        sh_full_d = sh_full_q;
`endif

        case (state_q)
            FILL: begin
                // cs_done is deliberately ignored here.
                if (xfer) begin
                    data_d[(NB - 1 - int'(cnt_q)) * 8 +: 8] = in_byte;
                    if (cnt_q == CW'(NB - 1)) begin
                        cnt_d   = '0;
                        state_d = SEND;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SEND: begin
                wdog_d  = '0;
                state_d = cs_done ? FILL : WAIT;
            end
            WAIT: begin
                if (cs_done) begin
                    state_d = FILL;
                    wdog_d  = '0;
                end else if (wdog_q != TW'(TIMEOUT)) begin
                    // Saturates at TIMEOUT; err stays set until reset.
                    wdog_d = wdog_q + 1'b1;
                    if (wdog_d == TW'(TIMEOUT)) begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = FILL;
        endcase

`ifdef CS_PACK_PREFILL_EN
        // While a frame is out with CS, further bytes go into the shadow buffer.
        if (state_q != FILL) begin
            if (xfer) begin
                sh_d[(NB - 1 - int'(sh_cnt_q)) * 8 +: 8] = in_byte;
                if (sh_cnt_q == CW'(NB - 1)) begin
                    sh_cnt_d  = '0;
                    sh_full_d = 1'b1;
                end else begin
                    sh_cnt_d = sh_cnt_q + 1'b1;
                end
            end
            if (cs_done) begin
                wdog_d = '0;
                if (sh_full_d) begin
                    data_d  = sh_d;
                    state_d = SEND;
                end else begin
                    // Copy only the bytes already collected; FILL resumes at that position.
                    for (int k = 0; k < NB; k++) begin
                        if (k < int'(sh_cnt_d)) begin
                            data_d[(NB - 1 - k) * 8 +: 8] = sh_d[(NB - 1 - k) * 8 +: 8];
                        end
                    end
                    cnt_d   = sh_cnt_d;
                    state_d = FILL;
                end
                sh_cnt_d  = '0;
                sh_full_d = 1'b0;
            end
        end
        in_ready_d = (state_d == FILL) | ~sh_full_d;
`else
        in_ready_d = (state_d == FILL);
`endif
        out_valid_d = (state_d == SEND);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            data_q      <= '0;
            wdog_q      <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            wdog_q      <= wdog_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef CS_PACK_PREFILL_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q      <= '0;
            sh_cnt_q  <= '0;
            sh_full_q <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            sh_cnt_q  <= sh_cnt_d;
            sh_full_q <= sh_full_d;
        end
    end
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data      = data_q;
    assign err       = err_q;

endmodule

// File: tb/tb_cs_byte_packer.sv
module tb_cs_byte_packer;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_byte = 8'h00;
    logic         in_byte_valid = 1'b0;
    logic         in_ready;
    logic [511:0] data;
    logic         out_valid;
    logic         cs_done = 1'b0;
    logic         err;

    int passes = 0;
    int checks = 0;
    int fails  = 0;

    // Reference model: bytes of the frame being collected, oldest first.
    logic [7:0]   mq[$];
    logic [511:0] exp_frame = '0;

    cs_byte_packer dut (
        .clk           (clk),
        .rst           (rst),
        .in_byte       (in_byte),
        .in_byte_valid (in_byte_valid),
        .in_ready      (in_ready),
        .data          (data),
        .out_valid     (out_valid),
        .cs_done       (cs_done),
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Frame from the model: the first byte sits in the top byte lane.
    function automatic logic [511:0] model_frame();
        logic [511:0] f;
        f = '0;
        for (int k = 0; k < 64; k++) f[511 - 8*k -: 8] = mq[k];
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit gapped);
        if (gapped) begin
            repeat ($urandom_range(0, 3)) begin
                in_byte_valid = 1'b0;
                in_byte = 8'($urandom);
                step();
                chk("gap_no_strobe", out_valid, 0);
            end
        end
        chk("in_ready_fill", in_ready, 1);
        in_byte = b;
        in_byte_valid = 1'b1;
        step();
        in_byte_valid = 1'b0;
        mq.push_back(b);
        if (mq.size() == 64) begin
            exp_frame = model_frame();
            mq.delete();
            chk("strobe", out_valid, 1);
            chk("frame", data, exp_frame);
        end else begin
            chk("no_strobe", out_valid, 0);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_byte_valid = 1'b0;
        cs_done = 1'b0;
        repeat (2) step();
        mq.delete();
        exp_frame = '0;
        chk("rst_data", data, 0);
        chk("rst_err", err, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;
    endtask

    task automatic cs_pulse();
        cs_done = 1'b1;
        step();
        cs_done = 1'b0;
    endtask

    initial begin
        // 1. reset
        do_reset();
        step();
        chk("in_ready_after_rst", in_ready, 1);

        // 2. bytes 0x00..0x3F back to back
        for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
        chk("top_byte", {504'd0, data[511:504]}, 0);
        chk("low_byte", {504'd0, data[7:0]}, 512'h3F);
        step();
        chk("strobe_one_cycle", out_valid, 0);
`ifndef CS_PACK_PREFILL_EN
        chk("wait_not_ready", in_ready, 0);
`endif
        repeat (4) begin
            step();
            chk("wait_data_held", data, exp_frame);
        end
        cs_pulse();
        chk("ready_after_done", in_ready, 1);
        chk("data_kept", data, exp_frame);
        chk("no_err", err, 0);
        // cs_done during FILL is ignored
        cs_pulse();
        chk("fill_done_ready", in_ready, 1);
        chk("fill_done_no_strobe", out_valid, 0);
        chk("fill_done_no_err", err, 0);

        // 3. gapped 0xFF frame, cs_done in the SEND cycle
        for (int i = 0; i < 64; i++) send_byte(8'hFF, 1'b1);
        cs_pulse();
        chk("send_done_no_strobe", out_valid, 0);
        chk("send_done_fill", in_ready, 1);

        // 4. watchdog
        for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b1);
        repeat (100) step();
        chk("err_before_timeout", err, 0);
        step();
        chk("err_at_timeout", err, 1);
        chk("timeout_data_held", data, exp_frame);
        cs_pulse();
        chk("err_sticky", err, 1);
        chk("ready_after_late_done", in_ready, 1);
        do_reset();
        step();
        chk("err_cleared", err, 0);

        // 5. reset mid-frame discards the partial frame
        for (int i = 0; i < 10; i++) send_byte(8'($urandom), 1'b1);
        repeat (20) begin
            step();
            chk("partial_no_strobe", out_valid, 0);
        end
        do_reset();
        step();
        for (int i = 0; i < 64; i++) send_byte(8'($urandom), 1'b0);
        cs_pulse();

        // partial frame held across a long idle gap
        for (int i = 0; i < 30; i++) send_byte(8'($urandom), 1'b1);
        repeat (25) begin
            step();
            chk("idle_no_strobe", out_valid, 0);
        end
        for (int i = 0; i < 34; i++) send_byte(8'($urandom), 1'b1);
        cs_pulse();

`ifdef CS_PACK_PREFILL_EN
        // 6. prefill: next frame collected while the first waits on CS
        begin
            int   idx;
            logic rdy;
            for (int i = 0; i < 64; i++) send_byte(8'(i), 1'b0);
            for (int k = 0; k < 64; k++) mq.push_back(8'(64 + k));
            exp_frame = model_frame();
            mq.delete();
            idx = 64;
            for (int c = 0; c < 200 && idx < 128; c++) begin
                in_byte = 8'(idx);
                in_byte_valid = 1'b1;
                rdy = in_ready;
                step();
                if (rdy) idx++;
            end
            in_byte_valid = 1'b0;
            chk("shadow_filled", 512'(idx), 512'd128);
            chk("shadow_full_not_ready", in_ready, 0);
            cs_pulse();
            chk("prefill_strobe", out_valid, 1);
            chk("prefill_frame", data, exp_frame);
            cs_pulse();
        end
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
